fpu_dispatch_rob: RTL and testbench
===================================

Name: fpu_dispatch_rob

Overview:
- Parametrised successor to the single fast/slow FPU hookup of the pipeline core.
- Accepts FP ops from the execute stage over valid/ready and dispatches each to one of NUM_UNITS FPU units with independent latencies.
- Tracks in-flight ops in a ROB_DEPTH-entry reorder buffer and returns results to writeback strictly in issue order, with the destination register address.
- Supports pipeline flush (branch mispredict) without losing track of results still in flight.

Parameters:
- XLEN, 32, operand/result width.
- NUM_UNITS, 2, number of FPU units (unit 0 = fast, unit 1 = slow by convention); 1..8.
- ROB_DEPTH, 4, reorder buffer entries; power of two, 2..16.
- Localparams: UNIT_W = max(1, clog2(NUM_UNITS)); IDX_W = clog2(ROB_DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- issue_valid  in  1  op offered by execute stage
- issue_ready  out  1  op accepted this cycle when high with issue_valid
- issue_unit  in  UNIT_W  target unit index
- issue_rd1/issue_rd2/issue_rd3  in  XLEN  operands
- issue_rm  in  3  rounding mode
- issue_funct5  in  5  FPU opcode
- issue_rd_addr  in  5  destination register
- flush  in  1  kill all in-flight ops
- unit_en  out  NUM_UNITS  one-hot start pulse per unit
- unit_rd1/unit_rd2/unit_rd3  out  XLEN  registered operand bus shared by all units
- unit_rm  out  3; unit_funct5  out  5  registered
- unit_busy  in  NUM_UNITS  unit cannot take a new op
- unit_valid  in  NUM_UNITS  result strobe per unit
- unit_result  in  NUM_UNITS*XLEN  packed results; unit u at [u*XLEN +: XLEN]
- wb_valid  out  1; wb_ready  in  1  writeback handshake
- wb_data  out  XLEN; wb_rd_addr  out  5
- occupancy  out  IDX_W+1  live ROB entries
- proto_err  out  1  sticky: result strobe with no outstanding op on that unit

Behaviour:
- Reset: all ROB entries and per-unit tag FIFOs cleared. unit_en=0, unit_* buses=0, wb_valid=0, wb_data=0, wb_rd_addr=0, occupancy=0, proto_err=0. issue_ready is combinational: it is 1 after reset while the target unit is not busy.
- ROB entry fields: busy, done, killed, rd_addr[5], data[XLEN]. Ring buffer with head/tail IDX_W pointers plus count.
- issue_ready = (count < ROB_DEPTH) && !unit_busy[issue_unit] && !flush. A free slot at commit does not count in the same cycle (no bypass).
- Accept at edge T:
  - Entry at tail gets busy=1, done=0, killed=0, rd_addr; tail++.
  - The tail index is pushed into the tag FIFO of issue_unit.
  - Operands, rm and funct5 are registered.
  - unit_en[issue_unit]=1 for exactly cycle T+1.
- Units return results in the order they received ops. When unit_valid[u] is high, pop the head of tag FIFO u, then write data and set done=1 in that entry.
- Several units strobing in the same cycle all write; their entries are distinct.
- Strobe on an empty FIFO: discarded and proto_err is set (sticky until rst).
- Commit:
  - When head entry is done && !killed: wb_valid=1, with wb_data/wb_rd_addr driven from the entry (combinational from ROB state). On wb_valid && wb_ready the entry is freed and head++.
  - When head entry is done && killed: freed silently with wb_valid=0, one entry per cycle.
- A result written at edge R is visible on wb_valid from cycle R+1. Back-to-back done entries commit one per cycle with no bubble.
- flush:
  - Every busy entry is marked killed at that edge; any accept in that cycle is suppressed.
  - Tag FIFOs are kept, so late results still land in the correct killed entry.
  - New ops may issue from the next cycle and occupy free slots behind killed ones.
  - wb_valid is forced 0 in the flush cycle.
- Simultaneous accept, result write and commit in one cycle are all legal; count = count + accept − free.
- rst mid-operation: everything is cleared immediately. In-flight results arriving after reset go to empty FIFOs and set proto_err. The integrator resets the units with the same rst.
- occupancy = count, registered.

Decomposition:
- Package fpu_dispatch_pkg: rob_entry_t struct, UNIT_FAST=0 / UNIT_SLOW=1 constants, and the FPU funct5 encodings shared with the FPU units.
- Sub-module fpu_tag_fifo (DEPTH=ROB_DEPTH, WIDTH=IDX_W, synchronous push/pop, empty/full flags), instantiated once per unit in a generate loop.

Test Plan:
- Single op to unit 0: accept at T, unit_en=2'b01 at T+1, unit_valid[0] with 0x3F800000 at T+3 → wb_valid at T+4 with wb_data=0x3F800000, wb_rd_addr=issue value.
- Out-of-order completion: slow op rd=5 to unit 1, then fast op rd=6 to unit 0. Unit 0 returns first → no wb_valid until unit 1 returns. Then rd=5 and rd=6 commit on consecutive cycles.
- Full: ROB_DEPTH=4 ops outstanding → issue_ready=0 and occupancy=4. One commit with wb_ready=1 → issue_ready=1 on the next cycle, not the same cycle.
- Flush with 3 ops in flight, then 1 new op: the 3 late results produce no wb_valid. The new op's result commits with correct data, and occupancy returns to 0.
- wb_ready held 0 for 5 cycles with 2 done entries → wb_valid, wb_data and wb_rd_addr stay stable, and no entry is lost.
- unit_valid[1] strobed with nothing outstanding → proto_err=1 and stays 1; rst → proto_err=0 and occupancy=0.

Source files
------------

// File: rtl/fpu_dispatch_pkg.sv
// Shared types and constants for the FPU dispatch / reorder-buffer block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ROB entry control struct, unit-index conventions, FPU funct5 opcodes.
package fpu_dispatch_pkg;

  // Unit index conventions used by the execute stage.
  localparam int UNIT_FAST = 0;
  localparam int UNIT_SLOW = 1;

  // FPU funct5 encodings shared with the FPU units (single precision).
  localparam logic [4:0] FUNCT5_FADD    = 5'b00000;
  localparam logic [4:0] FUNCT5_FSUB    = 5'b00001;
  localparam logic [4:0] FUNCT5_FMUL    = 5'b00010;
  localparam logic [4:0] FUNCT5_FDIV    = 5'b00011;
  localparam logic [4:0] FUNCT5_FSGNJ   = 5'b00100;
  localparam logic [4:0] FUNCT5_FMINMAX = 5'b00101;
  localparam logic [4:0] FUNCT5_FSQRT   = 5'b01011;
  localparam logic [4:0] FUNCT5_FCMP    = 5'b10100;
  localparam logic [4:0] FUNCT5_FCVT_WS = 5'b11000;
  localparam logic [4:0] FUNCT5_FCVT_SW = 5'b11010;

  // Control part of a ROB entry. The result data lives in a parallel array in
  // the top level because its width follows the XLEN parameter.
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       killed;
    logic [4:0] rd_addr;
  } rob_entry_t;

endpackage

// File: rtl/fpu_tag_fifo.sv
// Per-unit FIFO of ROB indices for ops issued to that unit, popped as results return.
// Latency: push visible at the head one cycle later; head read is combinational.
// Backpressure: push ignored when full, pop ignored when empty (caller guards both).
// Ports: clk/rst, push_i/push_dat_i, pop_i, pop_dat_o (current head), empty_o, full_o.
module fpu_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push, do_pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CNT_FULL);
  assign pop_dat_o = mem_q[rd_q];
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_dat_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (do_pop) rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/fpu_dispatch_rob.sv
// Dispatches FP ops to NUM_UNITS FPU units and commits results in issue order via a ROB.
// Latency: unit_en one cycle after accept; result written at edge R commits from cycle R+1.
// Backpressure: issue_ready drops on ROB full, target unit busy or flush; wb_ready stalls commit.
// Ports: issue_* (execute stage in), unit_* (to/from FPU units), wb_* (writeback out),
//        flush, occupancy (live entries), proto_err (sticky stray result strobe).
module fpu_dispatch_rob
  import fpu_dispatch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_UNITS = 2,
  parameter int ROB_DEPTH = 4,
  localparam int UNIT_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int IDX_W    = $clog2(ROB_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [UNIT_W-1:0]         issue_unit,
  input  logic [XLEN-1:0]           issue_rd1,
  input  logic [XLEN-1:0]           issue_rd2,
  input  logic [XLEN-1:0]           issue_rd3,
  input  logic [2:0]                issue_rm,
  input  logic [4:0]                issue_funct5,
  input  logic [4:0]                issue_rd_addr,
  input  logic                      flush,
  output logic [NUM_UNITS-1:0]      unit_en,
  output logic [XLEN-1:0]           unit_rd1,
  output logic [XLEN-1:0]           unit_rd2,
  output logic [XLEN-1:0]           unit_rd3,
  output logic [2:0]                unit_rm,
  output logic [4:0]                unit_funct5,
  input  logic [NUM_UNITS-1:0]      unit_busy,
  input  logic [NUM_UNITS-1:0]      unit_valid,
  input  logic [NUM_UNITS*XLEN-1:0] unit_result,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [XLEN-1:0]           wb_data,
  output logic [4:0]                wb_rd_addr,
  output logic [IDX_W:0]            occupancy,
  output logic                      proto_err
);

  localparam logic [IDX_W:0] ROB_FULL = (IDX_W + 1)'(ROB_DEPTH);

  rob_entry_t             rob_q  [ROB_DEPTH];
  rob_entry_t             rob_d  [ROB_DEPTH];
  logic [XLEN-1:0]        data_q [ROB_DEPTH];
  logic [XLEN-1:0]        data_d [ROB_DEPTH];
  logic [IDX_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]         count_q, count_d;
  logic [NUM_UNITS-1:0]   unit_en_q, unit_en_d;
  logic [XLEN-1:0]        rd1_q, rd1_d, rd2_q, rd2_d, rd3_q, rd3_d;
  logic [2:0]             rm_q, rm_d;
  logic [4:0]             f5_q, f5_d;
  logic                   proto_err_q, proto_err_d;

  logic [IDX_W-1:0]       fifo_head  [NUM_UNITS];
  logic [NUM_UNITS-1:0]   fifo_push, fifo_pop, fifo_empty, fifo_full;

  logic                   unit_ok, accept, free, commit_vld;
  rob_entry_t             head_ent;

  // Guards against an out-of-range unit index when NUM_UNITS is not a power of two.
  assign unit_ok = (32'(issue_unit) < 32'(NUM_UNITS));

  // Free slots from this cycle's commit are deliberately not bypassed into ready.
  assign issue_ready = (count_q < ROB_FULL) && unit_ok && !unit_busy[issue_unit]
                       && !fifo_full[issue_unit] && !flush;
  assign accept      = issue_valid && issue_ready;

  assign head_ent   = rob_q[head_q];
  assign commit_vld = head_ent.busy && head_ent.done && !head_ent.killed && !flush;
  // Killed entries retire silently once their late result has landed.
  assign free       = head_ent.busy && head_ent.done && (head_ent.killed || (wb_ready && !flush));

  assign wb_valid   = commit_vld;
  assign wb_data    = data_q[head_q];
  assign wb_rd_addr = head_ent.rd_addr;
  assign occupancy  = count_q;
  assign proto_err  = proto_err_q;
  assign unit_en    = unit_en_q;
  assign unit_rd1   = rd1_q;
  assign unit_rd2   = rd2_q;
  assign unit_rd3   = rd3_q;
  assign unit_rm    = rm_q;
  assign unit_funct5 = f5_q;

  // One tag FIFO per unit: units return results in the order they received ops,
  // so the FIFO head always names the ROB entry the next strobe belongs to.
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_tag
    assign fifo_push[u] = accept && (issue_unit == UNIT_W'(u));
    assign fifo_pop[u]  = unit_valid[u] && !fifo_empty[u];

    fpu_tag_fifo #(
      .DEPTH (ROB_DEPTH),
      .WIDTH (IDX_W)
    ) u_tag_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (fifo_push[u]),
      .push_dat_i (tail_q),
      .pop_i      (fifo_pop[u]),
      .pop_dat_o  (fifo_head[u]),
      .empty_o    (fifo_empty[u]),
      .full_o     (fifo_full[u])
    );
  end

  always_comb begin
    rob_d       = rob_q;
    data_d      = data_q;
    proto_err_d = proto_err_q;

    // Flush kills everything live; tags stay queued so late results still find their slot.
    if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (rob_q[i].busy) rob_d[i].killed = 1'b1;
      end
    end

    // Concurrent strobes from different units always target distinct entries.
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (unit_valid[u]) begin
        if (fifo_empty[u]) begin
          proto_err_d = 1'b1;
        end else begin
          rob_d[fifo_head[u]].done = 1'b1;
          data_d[fifo_head[u]]     = unit_result[u*XLEN +: XLEN];
        end
      end
    end

    // Head (freed) and tail (accepted) cannot coincide: accept needs a free slot.
    if (free) rob_d[head_q] = '0;
    if (accept) begin
      rob_d[tail_q].busy    = 1'b1;
      rob_d[tail_q].done    = 1'b0;
      rob_d[tail_q].killed  = 1'b0;
      rob_d[tail_q].rd_addr = issue_rd_addr;
    end

    head_d  = head_q + IDX_W'(free);
    tail_d  = tail_q + IDX_W'(accept);
    count_d = count_q + (IDX_W + 1)'(accept) - (IDX_W + 1)'(free);

    unit_en_d = '0;
    if (accept) unit_en_d[issue_unit] = 1'b1;
    rd1_d = accept ? issue_rd1     : rd1_q;
    rd2_d = accept ? issue_rd2     : rd2_q;
    rd3_d = accept ? issue_rd3     : rd3_q;
    rm_d  = accept ? issue_rm      : rm_q;
    f5_d  = accept ? issue_funct5  : f5_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob_q[i]  <= '0;
        data_q[i] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      unit_en_q   <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      rd3_q       <= '0;
      rm_q        <= '0;
      f5_q        <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rob_q       <= rob_d;
      data_q      <= data_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      unit_en_q   <= unit_en_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      rd3_q       <= rd3_d;
      rm_q        <= rm_d;
      f5_q        <= f5_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_fpu_dispatch_rob.sv
// Bench for fpu_dispatch_rob: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against an in-order queue model.
module tb_fpu_dispatch_rob;
  import fpu_dispatch_pkg::*;

  localparam int XL = 32;
  localparam int NU = 2;
  localparam int RD = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           iv;
  logic           issue_ready;
  logic [0:0]     iunit;
  logic [XL-1:0]  ird1, ird2, ird3;
  logic [2:0]     irm;
  logic [4:0]     if5, ird;
  logic           flush;
  logic [NU-1:0]  unit_en;
  logic [XL-1:0]  unit_rd1, unit_rd2, unit_rd3;
  logic [2:0]     unit_rm;
  logic [4:0]     unit_funct5;
  logic [NU-1:0]  ubusy, uval;
  logic [NU*XL-1:0] ures;
  logic           wb_valid, wbr;
  logic [XL-1:0]  wb_data;
  logic [4:0]     wb_rd_addr;
  logic [2:0]     occupancy;
  logic           proto_err;

  always #5 clk = ~clk;

  fpu_dispatch_rob #(.XLEN(XL), .NUM_UNITS(NU), .ROB_DEPTH(RD)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(iv), .issue_ready(issue_ready), .issue_unit(iunit),
    .issue_rd1(ird1), .issue_rd2(ird2), .issue_rd3(ird3),
    .issue_rm(irm), .issue_funct5(if5), .issue_rd_addr(ird),
    .flush(flush),
    .unit_en(unit_en), .unit_rd1(unit_rd1), .unit_rd2(unit_rd2), .unit_rd3(unit_rd3),
    .unit_rm(unit_rm), .unit_funct5(unit_funct5),
    .unit_busy(ubusy), .unit_valid(uval), .unit_result(ures),
    .wb_valid(wb_valid), .wb_ready(wbr), .wb_data(wb_data), .wb_rd_addr(wb_rd_addr),
    .occupancy(occupancy), .proto_err(proto_err)
  );

  // ---------------- reference model: ops listed in issue order ----------------
  int          live[$];          // op ids holding a ROB slot, oldest first
  int          tagq[NU][$];      // per unit: op ids awaiting a result
  int          envt[NU][$];      // per unit: cycle at which the unit may answer
  bit          m_done[4096];
  bit          m_killed[4096];
  logic [4:0]  m_rd[4096];
  logic [31:0] m_data[4096];
  bit          m_perr;
  logic [NU-1:0] e_en;
  logic [31:0] e_rd1, e_rd2, e_rd3;
  logic [2:0]  e_rm;
  logic [4:0]  e_f5;
  int          next_id;
  int          cyc;
  int          n_cmp;
  int          n_fail;
  logic [4:0]  ops[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit exp_ready();
    return (live.size() < RD) && !ubusy[iunit] && !flush;
  endfunction

  function automatic bit head_done();
    return (live.size() > 0) && m_done[live[0] & 4095];
  endfunction

  function automatic bit exp_wbv();
    return head_done() && !m_killed[live[0] & 4095] && !flush;
  endfunction

  task automatic model_clear();
    live.delete();
    for (int u = 0; u < NU; u++) begin
      tagq[u].delete();
      envt[u].delete();
    end
    m_perr = 1'b0;
    e_en = '0; e_rd1 = '0; e_rd2 = '0; e_rd3 = '0; e_rm = '0; e_f5 = '0;
  endtask

  // Checks every DUT output against the model for the current cycle.
  task automatic compare();
    int h;
    chk("issue_ready", issue_ready, exp_ready());
    chk("wb_valid", wb_valid, exp_wbv());
    if (exp_wbv()) begin
      h = live[0] & 4095;
      chk("wb_data", wb_data, m_data[h]);
      chk("wb_rd_addr", wb_rd_addr, m_rd[h]);
    end
    chk("occupancy", occupancy, live.size());
    chk("proto_err", proto_err, m_perr);
    chk("unit_en", unit_en, e_en);
    if (e_en != '0) begin
      chk("unit_rd1", unit_rd1, e_rd1);
      chk("unit_rd2", unit_rd2, e_rd2);
      chk("unit_rd3", unit_rd3, e_rd3);
      chk("unit_rm", unit_rm, e_rm);
      chk("unit_funct5", unit_funct5, e_f5);
    end
  endtask

  // Advances the model across the coming clock edge.
  task automatic model_step();
    bit acc;
    int id, t;
    acc = iv && exp_ready();
    if (head_done() && (m_killed[live[0] & 4095] || (wbr && !flush))) void'(live.pop_front());
    if (flush) foreach (live[i]) m_killed[live[i] & 4095] = 1'b1;
    for (int u = 0; u < NU; u++) begin
      if (uval[u]) begin
        if (tagq[u].size() == 0) m_perr = 1'b1;
        else begin
          id = tagq[u].pop_front();
          m_done[id & 4095] = 1'b1;
          m_data[id & 4095] = ures[u*XL +: XL];
        end
      end
    end
    e_en = '0;
    if (acc) begin
      id = next_id++;
      m_done[id & 4095] = 1'b0;
      m_killed[id & 4095] = 1'b0;
      m_rd[id & 4095] = ird;
      live.push_back(id);
      tagq[iunit].push_back(id);
      t = cyc + $urandom_range(2, 8);
      if (envt[iunit].size() > 0 && t < envt[iunit][$]) t = envt[iunit][$];
      envt[iunit].push_back(t);
      e_en[iunit] = 1'b1;
      e_rd1 = ird1; e_rd2 = ird2; e_rd3 = ird3; e_rm = irm; e_f5 = if5;
    end
  endtask

  task automatic cycle();
    #2;
    compare();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    iv = 1'b0; flush = 1'b0; uval = '0; ubusy = '0; wbr = 1'b1;
  endtask

  task automatic issue(input int u, input logic [4:0] rd);
    iv = 1'b1; iunit = 1'(u); ird = rd;
    ird1 = $urandom; ird2 = $urandom; ird3 = $urandom;
    irm = 3'($urandom_range(0, 7)); if5 = ops[$urandom_range(0, 4)];
  endtask

  task automatic strobe(input int u, input logic [31:0] d);
    uval = '0; uval[u] = 1'b1; ures[u*XL +: XL] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    iunit = '0;
    #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd_addr", wb_rd_addr, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_unit_en", unit_en, 0);
    chk("rst_unit_rd1", unit_rd1, 0);
    chk("rst_issue_ready", issue_ready, 1);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; next_id = 0;
    ops[0] = FUNCT5_FADD; ops[1] = FUNCT5_FSUB; ops[2] = FUNCT5_FMUL;
    ops[3] = FUNCT5_FDIV; ops[4] = FUNCT5_FSQRT;
    ird1 = '0; ird2 = '0; ird3 = '0; irm = '0; if5 = '0; ird = '0; ures = '0;
    do_reset();

    // Single op to the fast unit: accept T, en T+1, result T+3, writeback T+4.
    issue(UNIT_FAST, 5'd7); ird1 = 32'h3F800000;
    cycle();
    idle(); #1;
    chk("single_unit_en", unit_en, 2'b01);
    chk("single_unit_rd1", unit_rd1, 32'h3F800000);
    cycle();
    cycle();
    strobe(UNIT_FAST, 32'h3F800000);
    cycle();
    idle(); #1;
    chk("single_wb_valid", wb_valid, 1);
    chk("single_wb_data", wb_data, 32'h3F800000);
    chk("single_wb_rd", wb_rd_addr, 5'd7);
    cycle();
    #1; chk("single_occ_after", occupancy, 0);
    cycle();

    // Out-of-order completion, in-order commit.
    issue(UNIT_SLOW, 5'd5); cycle();
    issue(UNIT_FAST, 5'd6); cycle();
    idle(); cycle();
    strobe(UNIT_FAST, 32'h40C00000); cycle();
    idle(); #1; chk("ooo_hold_a", wb_valid, 0); cycle();
    #1; chk("ooo_hold_b", wb_valid, 0); cycle();
    strobe(UNIT_SLOW, 32'h40A00000); cycle();
    idle(); #1;
    chk("ooo_first_rd", wb_rd_addr, 5'd5);
    chk("ooo_first_data", wb_data, 32'h40A00000);
    cycle();
    #1;
    chk("ooo_second_vld", wb_valid, 1);
    chk("ooo_second_rd", wb_rd_addr, 5'd6);
    cycle();

    // ROB full, and no same-cycle reuse of a committing slot.
    wbr = 1'b0;
    for (int k = 0; k < RD; k++) begin issue(UNIT_FAST, 5'(10 + k)); wbr = 1'b0; cycle(); end
    issue(UNIT_FAST, 5'd14); wbr = 1'b0; #1;
    chk("full_ready", issue_ready, 0);
    chk("full_occ", occupancy, 4);
    cycle();
    strobe(UNIT_FAST, 32'h00000011); cycle();
    uval = '0; wbr = 1'b1; #1;
    chk("full_commit_vld", wb_valid, 1);
    chk("full_no_bypass", issue_ready, 0);
    cycle();
    #1;
    chk("full_ready_next", issue_ready, 1);
    chk("full_occ_next", occupancy, 3);
    cycle();
    idle();
    for (int k = 0; k < RD; k++) begin strobe(UNIT_FAST, 32'(k + 32'h20)); cycle(); end
    idle();
    repeat (3) cycle();
    #1; chk("full_drain_occ", occupancy, 0);

    // Flush with three ops in flight, then one new op.
    issue(UNIT_FAST, 5'd20); cycle();
    issue(UNIT_SLOW, 5'd21); cycle();
    issue(UNIT_FAST, 5'd22); cycle();
    issue(UNIT_FAST, 5'd30); flush = 1'b1; #1;
    chk("flush_ready", issue_ready, 0);
    chk("flush_wb_forced", wb_valid, 0);
    cycle();
    flush = 1'b0; issue(UNIT_SLOW, 5'd23); cycle();
    idle();
    strobe(UNIT_FAST, 32'hDEAD0000); cycle();
    strobe(UNIT_SLOW, 32'hDEAD0001); #1; chk("flush_late_a", wb_valid, 0); cycle();
    strobe(UNIT_FAST, 32'hDEAD0002); #1; chk("flush_late_b", wb_valid, 0); cycle();
    strobe(UNIT_SLOW, 32'h40490FDB); #1; chk("flush_late_c", wb_valid, 0); cycle();
    idle(); #1;
    chk("flush_new_vld", wb_valid, 1);
    chk("flush_new_data", wb_data, 32'h40490FDB);
    chk("flush_new_rd", wb_rd_addr, 5'd23);
    cycle();
    #1; chk("flush_occ_zero", occupancy, 0);
    cycle();

    // Writeback stall with two done entries.
    wbr = 1'b0;
    issue(UNIT_FAST, 5'd1); wbr = 1'b0; cycle();
    issue(UNIT_FAST, 5'd2); wbr = 1'b0; cycle();
    iv = 1'b0;
    strobe(UNIT_FAST, 32'hAAAA0001); cycle();
    strobe(UNIT_FAST, 32'hAAAA0002); cycle();
    uval = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_vld", wb_valid, 1);
      chk("stall_data", wb_data, 32'hAAAA0001);
      chk("stall_rd", wb_rd_addr, 5'd1);
      cycle();
    end
    wbr = 1'b1; cycle();
    #1;
    chk("stall_second_data", wb_data, 32'hAAAA0002);
    chk("stall_second_rd", wb_rd_addr, 5'd2);
    cycle();
    #1; chk("stall_occ_zero", occupancy, 0);

    // Stray strobe, stickiness, cleared by reset.
    strobe(UNIT_SLOW, 32'h1); cycle();
    idle();
    for (int k = 0; k < 3; k++) begin #1; chk("perr_sticky", proto_err, 1); cycle(); end
    do_reset();

    // Reset with an op in flight: its late result hits an empty tag FIFO.
    issue(UNIT_SLOW, 5'd9); cycle();
    idle(); cycle();
    do_reset();
    strobe(UNIT_SLOW, 32'h5); cycle();
    idle(); #1;
    chk("late_after_rst_perr", proto_err, 1);
    chk("late_after_rst_occ", occupancy, 0);
    cycle();
    do_reset();

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      if (k == 750) do_reset();
      iv = 1'($urandom_range(0, 1));
      iunit = 1'($urandom_range(0, 1));
      ird = 5'($urandom);
      ird1 = $urandom; ird2 = $urandom; ird3 = $urandom;
      irm = 3'($urandom_range(0, 7));
      if5 = ops[$urandom_range(0, 4)];
      ubusy = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      flush = ($urandom_range(0, 39) == 0);
      wbr = ($urandom_range(0, 3) != 0);
      uval = '0;
      for (int u = 0; u < NU; u++) begin
        if (envt[u].size() > 0 && cyc >= envt[u][0] && $urandom_range(0, 3) != 0) begin
          uval[u] = 1'b1;
          ures[u*XL +: XL] = $urandom;
          void'(envt[u].pop_front());
        end
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
